// File: rtl/pipe_dmem_pkg.sv
// Shared encodings for the pipeline data-memory port: access sizes and FSM states.
package pipe_dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store byte enables / replicated data, load extract and extend.
// PIPE_DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_lane_fmt
  import pipe_dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [1:0]  off_s;
  logic [31:0] shifted_s;

  // Effective lane offset and error classification.
  always_comb begin
    err   = 1'b0;
    off_s = 2'b00;
    case (size)
      SZ_B: off_s = offset;
      SZ_H: begin
        off_s = {offset[1], 1'b0};
`ifdef PIPE_DMEM_MISALIGN_TRAP_EN
        err = offset[0];
`else
        err = 1'b0;
`endif
      end
      SZ_W: begin
        off_s = 2'b00;
`ifdef PIPE_DMEM_MISALIGN_TRAP_EN
        err = (offset != 2'b00);
`else
        err = 1'b0;
`endif
      end
      default: err = 1'b1;
    endcase
  end

  // Lane enables, replicated store data and extended load data.
  always_comb begin
    shifted_s   = rword >> {off_s, 3'b000};
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0000_0000;
    rdata_ext   = 32'h0000_0000;
    if (err) begin
      byte_en   = 4'b0000;
      rdata_ext = 32'h0000_0000;
    end else begin
      case (size)
        SZ_B: begin
          byte_en     = 4'b0001 << off_s;
          wdata_lanes = {4{wdata[7:0]}};
          rdata_ext   = is_unsigned ? {24'h00_0000, shifted_s[7:0]}
                                    : {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
        SZ_H: begin
          byte_en     = 4'b0011 << off_s;
          wdata_lanes = {2{wdata[15:0]}};
          rdata_ext   = is_unsigned ? {16'h0000, shifted_s[15:0]}
                                    : {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
        SZ_W: begin
          byte_en     = 4'b1111;
          wdata_lanes = wdata;
          rdata_ext   = shifted_s;
        end
        default: begin
          byte_en   = 4'b0000;
          rdata_ext = 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_dmem.sv
// Pipeline M-stage data memory with fixed wait states and one-cycle response pulse.
// Optional PIPE_DMEM_MISALIGN_TRAP_EN (in dmem_lane_fmt) traps misaligned accesses.
module pipe_dmem
  import pipe_dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        stall,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAT_M1 = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_t        state_r;
  logic [2:0]    cnt_r;
  logic          cap_we_r;
  logic [1:0]    cap_size_r;
  logic          cap_uns_r;
  logic [AW+1:0] cap_addr_r;
  logic [31:0]   cap_wdata_r;
  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic [31:0]   rsp_rdata_r;

  logic [31:0]   mem_r [DEPTH];

  logic          cur_we_s;
  logic [1:0]    cur_size_s;
  logic          cur_uns_s;
  logic [AW+1:0] cur_addr_s;
  logic [31:0]   cur_wdata_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rword_s;
  logic [3:0]    byte_en_s;
  logic [31:0]   wdata_lanes_s;
  logic [31:0]   rdata_ext_s;
  logic          fmt_err_s;
  logic          enter_resp_s;
  logic          mem_we_s;
  logic [31:0]   rsp_rdata_nxt_s;
  logic          unused_addr_s;

  // In IDLE the live request is the one being accepted; afterwards only the capture counts.
  always_comb begin
    if (state_r == IDLE) begin
      cur_we_s    = req_we;
      cur_size_s  = req_size;
      cur_uns_s   = req_unsigned;
      cur_addr_s  = req_addr[AW+1:0];
      cur_wdata_s = req_wdata;
    end else begin
      cur_we_s    = cap_we_r;
      cur_size_s  = cap_size_r;
      cur_uns_s   = cap_uns_r;
      cur_addr_s  = cap_addr_r;
      cur_wdata_s = cap_wdata_r;
    end
  end

  assign unused_addr_s = ^req_addr[31:AW+2];
  assign idx_s         = cur_addr_s[AW+1:2];
  assign rword_s       = mem_r[idx_s];

  dmem_lane_fmt u_lane_fmt (
    .size        (cur_size_s),
    .is_unsigned (cur_uns_s),
    .offset      (cur_addr_s[1:0]),
    .wdata       (cur_wdata_s),
    .rword       (rword_s),
    .byte_en     (byte_en_s),
    .wdata_lanes (wdata_lanes_s),
    .rdata_ext   (rdata_ext_s),
    .err         (fmt_err_s)
  );

  assign enter_resp_s    = ((state_r == IDLE) && req_valid && (LATENCY == 0)) ||
                           ((state_r == WAIT) && (cnt_r == 3'd0));
  assign mem_we_s        = enter_resp_s && cur_we_s && !fmt_err_s && !reset;
  assign rsp_rdata_nxt_s = cur_we_s ? 32'h0000_0000 : rdata_ext_s;

  // Byte-lane write into the array on the edge that enters RESP; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_s && byte_en_s[b]) begin
        mem_r[idx_s][8*b +: 8] <= wdata_lanes_s[8*b +: 8];
      end
    end
  end

  // Request FSM with capture registers and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      cap_we_r    <= 1'b0;
      cap_size_r  <= 2'b00;
      cap_uns_r   <= 1'b0;
      cap_addr_r  <= '0;
      cap_wdata_r <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          if (req_valid) begin
            cap_we_r    <= req_we;
            cap_size_r  <= req_size;
            cap_uns_r   <= req_unsigned;
            cap_addr_r  <= req_addr[AW+1:0];
            cap_wdata_r <= req_wdata;
            if (LATENCY == 0) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= fmt_err_s;
              rsp_rdata_r <= rsp_rdata_nxt_s;
            end else begin
              state_r <= WAIT;
              cnt_r   <= LAT_M1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_r == 3'd0) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= fmt_err_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        RESP: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 3'd0;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign stall     = (state_r == IDLE) ? req_valid : (state_r != RESP);
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
